// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for the proc2mem/mem2proc interface.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef logic [3:0]  mem_tag_t;
  typedef logic [63:0] mem_data_t;

  localparam mem_tag_t TAG_NONE = 4'd0;

  // One in-flight completion: tag plus load data (zero for stores).
  typedef struct packed {
    logic      valid;
    mem_tag_t  tag;
    mem_data_t data;
  } resp_entry_t;

  // Round-robin tag sequence 1..num_tags; 0 is reserved for "nothing".
  function automatic mem_tag_t tag_advance(input mem_tag_t tag, input int unsigned num_tags);
    return (32'(tag) >= num_tags) ? mem_tag_t'(1) : tag + mem_tag_t'(1);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-length delay line carrying accepted transactions to their completion cycle.
module mem_resp_pipe
  import mem_bus_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  resp_entry_t in_entry,
  output resp_entry_t out_entry
);

  resp_entry_t [LATENCY-1:0] stage_q;
  resp_entry_t [LATENCY-1:0] stage_d;

  // Shift every stage forward by one; the newest entry enters stage 0.
  always_comb begin
    stage_d[0] = in_entry;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops everything still in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_entry = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: accepts one load/store per cycle, tags it, and
// completes it a fixed number of cycles later.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 14,
  parameter int NUM_TAGS  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_address,
  input  logic [63:0] proc2mem_data,
  input  logic        busy_inject,
  output logic [3:0]  mem2proc_response,
  output logic [3:0]  mem2proc_tag,
  output logic [63:0] mem2proc_data,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (LATENCY < 1 || LATENCY >= NUM_TAGS || NUM_TAGS > 15 ||
      ADDR_BITS < 1 || ADDR_BITS > 63) begin : g_bad_params
    $error("mem_bus_responder: illegal LATENCY/NUM_TAGS/ADDR_BITS combination");
  end

  bus_cmd_e               cmd;
  logic                   is_load;
  logic                   is_store;
  logic                   accept;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   index;
  mem_tag_t               next_tag_q, next_tag_d;
  logic                   addr_err_q, addr_err_d;
  resp_entry_t            issue_entry;
  resp_entry_t            done_entry;
  mem_data_t              mem_q [DEPTH];

  assign cmd = bus_cmd_e'(proc2mem_command);

  // Accept decision, same-cycle tag response, and the entry launched down the pipe.
  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    is_load           = (cmd == BUS_LOAD);
    is_store          = (cmd == BUS_STORE);
    accept            = (is_load || is_store) && !busy_inject && !reset;
    in_range          = (proc2mem_address[63:ADDR_BITS] == '0);
    index             = proc2mem_address[ADDR_BITS-1:0];
    mem2proc_response = accept ? next_tag_q : TAG_NONE;
    next_tag_d        = accept ? tag_advance(next_tag_q, unsigned'(NUM_TAGS)) : next_tag_q;
    addr_err_d        = addr_err_q | (accept & ~in_range);
    issue_entry       = '0;
    if (accept) begin
      issue_entry.valid = 1'b1;
      issue_entry.tag   = next_tag_q;
      if (is_load && in_range) begin
        issue_entry.data = mem_q[index];
      end
    end
  end

  // Backing array write port; out-of-range stores are dropped.
  // NOTE: the array has no reset -- contents survive reset, and clearing it would be a huge mux.
  always_ff @(posedge clock) begin
    if (accept && is_store && in_range) begin
      mem_q[index] <= proc2mem_data;
    end
  end

  // Tag counter and sticky error flag.
  // NOTE: state is updated with non-blocking assignments so all flops sample together.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_tag_q <= mem_tag_t'(1);
      addr_err_q <= 1'b0;
    end else begin
      next_tag_q <= next_tag_d;
      addr_err_q <= addr_err_d;
    end
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_entry  (issue_entry),
    .out_entry (done_entry)
  );

  assign mem2proc_tag  = done_entry.valid ? done_entry.tag  : TAG_NONE;
  assign mem2proc_data = done_entry.valid ? done_entry.data : '0;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: a LATENCY=4 and a LATENCY=1 responder driven in lock step.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd   = 2'd0;
  logic [63:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic        busy  = 1'b0;

  logic [3:0]  resp4, tag4, resp1, tag1;
  logic [63:0] data4, data1;
  logic        err4, err1;

  int       checks  = 0;
  int       errors  = 0;
  int       cyc     = 0;
  bit       mon_en  = 1'b0;
  mem_tag_t exp_tag = 4'd1;
  logic     exp_err = 1'b0;

  typedef struct {
    int          cyc;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;

  exp_t        q4[$];
  exp_t        q1[$];
  logic [63:0] model [int];

  mem_bus_responder #(.LATENCY(4), .ADDR_BITS(14), .NUM_TAGS(15)) u_dut4 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_address  (addr),
    .proc2mem_data     (wdata),
    .busy_inject       (busy),
    .mem2proc_response (resp4),
    .mem2proc_tag      (tag4),
    .mem2proc_data     (data4),
    .addr_err          (err4)
  );

  mem_bus_responder #(.LATENCY(1), .ADDR_BITS(14), .NUM_TAGS(15)) u_dut1 (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (cmd),
    .proc2mem_address  (addr),
    .proc2mem_data     (wdata),
    .busy_inject       (busy),
    .mem2proc_response (resp1),
    .mem2proc_tag      (tag1),
    .mem2proc_data     (data1),
    .addr_err          (err1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One bus cycle: drive inputs after the edge, check the combinational
  // response and the error flag, then update the reference model.
  task automatic drive(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                       input logic b, input logic r);
    logic        acc;
    logic        in_rng;
    logic [3:0]  exp_resp;
    logic [63:0] exp_d;
    int          idx;
    @(posedge clock);
    #1;
    cmd = c; addr = a; wdata = d; busy = b; reset = r;
    acc      = !r && !b && (c == 2'd1 || c == 2'd2);
    exp_resp = acc ? exp_tag : 4'd0;
    in_rng   = (a < 64'h4000);
    idx      = int'(a[13:0]);
    #2;
    check("resp_l4", 64'(resp4), 64'(exp_resp));
    check("resp_l1", 64'(resp1), 64'(exp_resp));
    check("err_l4", 64'(err4), 64'(exp_err));
    check("err_l1", 64'(err1), 64'(exp_err));
    if (r) begin
      while (q4.size() > 0 && q4[q4.size()-1].cyc > cyc) q4.delete(q4.size()-1);
      while (q1.size() > 0 && q1[q1.size()-1].cyc > cyc) q1.delete(q1.size()-1);
      exp_tag = 4'd1;
      exp_err = 1'b0;
    end else if (acc) begin
      exp_d = 64'd0;
      if (c == 2'd1 && in_rng) exp_d = model.exists(idx) ? model[idx] : 64'd0;
      if (c == 2'd2 && in_rng) model[idx] = d;
      if (!in_rng) exp_err = 1'b1;
      q4.push_back('{cyc + 4, exp_tag, exp_d});
      q1.push_back('{cyc + 1, exp_tag, exp_d});
      exp_tag = (exp_tag == 4'd15) ? 4'd1 : exp_tag + 4'd1;
    end
  endtask

  task automatic idle();
    drive(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [63:0] a);
    drive(BUS_LOAD, a, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] d);
    drive(BUS_STORE, a, d, 1'b0, 1'b0);
  endtask

  // Completion monitors: each cycle either the scheduled completion or silence.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      e.cyc = cyc; e.tag = 4'd0; e.data = 64'd0;
      if (q4.size() > 0 && q4[0].cyc == cyc) e = q4.pop_front();
      check("tag_l4", 64'(tag4), 64'(e.tag));
      check("data_l4", data4, e.data);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      e.cyc = cyc; e.tag = 4'd0; e.data = 64'd0;
      if (q1.size() > 0 && q1[0].cyc == cyc) e = q1.pop_front();
      check("tag_l1", 64'(tag1), 64'(e.tag));
      check("data_l1", data1, e.data);
    end
  end

  initial begin
    drive(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b1);
    mon_en = 1'b1;
    check("rst_tag", 64'(tag4), 64'd0);
    check("rst_data", data4, 64'd0);
    check("rst_err", 64'(err4), 64'd0);

    // Store then load of the same entry two cycles apart.
    st(64'd8, 64'hDEAD_BEEF_0000_0001);
    idle();
    ld(64'd8);
    repeat (6) idle();

    // Fill 20 entries, reset so the burst starts at tag 1, then 20 back-to-back loads.
    for (int i = 0; i < 20; i++) st(64'(100 + i), {32'hA5A5_0000 | 32'(i), 32'(i * 7 + 3)});
    repeat (6) idle();
    drive(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) ld(64'(100 + i));
    repeat (6) idle();

    // Back-pressure: load held under busy for three cycles, then accepted.
    repeat (3) drive(BUS_LOAD, 64'd8, 64'd0, 1'b1, 1'b0);
    ld(64'd8);
    repeat (6) idle();

    // Out-of-range store must not alias onto index 0.
    st(64'd0, 64'h0123_4567_89AB_CDEF);
    st(64'h4000, 64'hBAD0_BAD0_BAD0_BAD0);
    idle();
    ld(64'd0);
    repeat (6) idle();

    // Store immediately followed by load of the same index.
    st(64'd5, 64'h5555_AAAA_0000_0005);
    ld(64'd5);
    repeat (6) idle();

    // Reset while loads are in flight; the load under reset is refused.
    ld(64'd8);
    ld(64'd0);
    drive(BUS_LOAD, 64'd5, 64'd0, 1'b0, 1'b1);
    ld(64'd5);

    for (int i = 0; i < 20 && (q4.size() > 0 || q1.size() > 0); i++) idle();
    check("drain_l4", 64'(q4.size()), 64'd0);
    check("drain_l1", 64'(q1.size()), 64'd0);
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
